// File: rtl/mux_2x1_if.sv
// Selector bus: two data inputs and a select in, combinational and registered results out.
interface mux_2x1_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             sel_chg;

    modport master (
        output a,
        output b,
        output sel,
        input  y,
        input  y_q,
        input  sel_chg
    );

    modport slave (
        input  a,
        input  b,
        input  sel,
        output y,
        output y_q,
        output sel_chg
    );
endinterface

// File: rtl/mux_2x1.sv
// 2-to-1 datapath selector with a zero-latency output, a registered copy
// of it, and a one-cycle flag on every change of the registered select.
module mux_2x1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    mux_2x1_if.slave    bus
);
    localparam int unsigned W = WIDTH;

    logic [W-1:0] y;
    logic [W-1:0] y_q;
    logic         sel_d;
    logic         sel_chg;

    // An if-test routes any non-1 select (0, X, Z) to a, keeping every bit on one source.
    always_comb begin
        y = bus.a;
        if (bus.sel) begin
            y = bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= W'(0);
            sel_d   <= 1'b0;
            sel_chg <= 1'b0;
        end else begin
            y_q     <= y;
            sel_d   <= bus.sel;
            sel_chg <= (bus.sel != sel_d);
        end
    end

    assign bus.y       = y;
    assign bus.y_q     = y_q;
    assign bus.sel_chg = sel_chg;
endmodule

// File: tb/tb_mux_2x1.sv
// Directed-vector bench for mux_2x1 at WIDTH=1 and WIDTH=8.
module tb_mux_2x1;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    // {a, b, sel, expected y}
    logic [3:0] tt [7];
    // {sel, rst, expected y_q, expected sel_chg}; a=1, b=0 throughout
    logic [3:0] mr [5];

    mux_2x1_if #(.WIDTH(1)) bus1 ();
    mux_2x1_if #(.WIDTH(8)) bus8 ();

    mux_2x1 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mux_2x1 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tt = '{4'b0000, 4'b0100, 4'b0111, 4'b1001, 4'b1010, 4'b1101, 4'b1111};
        mr = '{4'b0011, 4'b1001, 4'b0100, 4'b1001, 4'b0011};

        rst = 1'b1;
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.sel = 1'b0;
        bus8.a = 8'h00; bus8.b = 8'h00; bus8.sel = 1'b0;

        // reset held for two edges
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_y_q", 8'(bus1.y_q), 8'h00);
            check("rst_sel_chg", 8'(bus1.sel_chg), 8'h00);
            check("rst_y", 8'(bus1.y), 8'h01);
        end

        // combinational truth table, 10 ns per step
        for (int i = 0; i < 7; i++) begin
            bus1.a = tt[i][3];
            bus1.b = tt[i][2];
            bus1.sel = tt[i][1];
            #1;
            check($sformatf("tt%0d_y", i), 8'(bus1.y), 8'(tt[i][0]));
            #9;
        end

        // registered latency
        rst = 1'b0;
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.sel = 1'b0;
        tick();
        tick();
        check("lat_y_q_pre", 8'(bus1.y_q), 8'h01);
        check("lat_chg_pre", 8'(bus1.sel_chg), 8'h00);
        bus1.sel = 1'b1;
        #1;
        check("lat_y_now", 8'(bus1.y), 8'h00);
        check("lat_y_q_hold", 8'(bus1.y_q), 8'h01);
        tick();
        check("lat_y_q_post", 8'(bus1.y_q), 8'h00);
        check("lat_chg_post", 8'(bus1.sel_chg), 8'h01);
        tick();
        check("lat_chg_drop", 8'(bus1.sel_chg), 8'h00);

        // 8-bit width
        bus8.a = 8'hA5; bus8.b = 8'h3C; bus8.sel = 1'b0;
        #1;
        check("w8_y_a", bus8.y, 8'hA5);
        tick();
        check("w8_y_q_a", bus8.y_q, 8'hA5);
        bus8.sel = 1'b1;
        #1;
        check("w8_y_b", bus8.y, 8'h3C);
        check("w8_y_q_hold", bus8.y_q, 8'hA5);
        tick();
        check("w8_y_q_b", bus8.y_q, 8'h3C);
        check("w8_chg", 8'(bus8.sel_chg), 8'h01);

        // toggling select with a one-edge reset in the middle
        bus1.a = 1'b1; bus1.b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus1.sel = mr[i][3];
            rst = mr[i][2];
            tick();
            check($sformatf("mr%0d_y_q", i), 8'(bus1.y_q), 8'(mr[i][1]));
            check($sformatf("mr%0d_chg", i), 8'(bus1.sel_chg), 8'(mr[i][0]));
        end
        rst = 1'b0;

        // unknown select falls back to a
        bus1.a = 1'b0; bus1.b = 1'b1; bus1.sel = 1'bx;
        #1;
        check("selx_y", 8'(bus1.y), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
